// File: rtl/ram_wr_fsm.sv
// ---------------------------------------------------------------------------
// ram_wr_fsm
//
// Purpose:
//   Capture FSM that streams qualified samples into a BRAM write port.
//   A run fills every address of the memory (DEPTH = 2**NB_ADDR) starting at
//   address 0. It then parks in DONE so the read side knows the buffer is
//   complete. The FSM returns to IDLE once the run request is released.
//
// Configuration macro:
//   RAM_WR_TRIGGER_EN - when defined, adds the i_trigger port and the ARM
//                       state. IDLE then goes to ARM on i_run, and writing
//                       starts only after a trigger. When undefined, IDLE
//                       goes straight to WRITE and encoding 2'b01 decodes
//                       as IDLE.
//
// Ports:
//   clock      in   system clock, rising-edge active
//   i_reset    in   synchronous active-high reset
//   i_run      in   capture request (level)
//   i_valid    in   sample strobe qualifying i_data
//   i_data     in   sample to store [NB_DATA]
//   i_trigger  in   capture trigger (RAM_WR_TRIGGER_EN only)
//   o_wr_en    out  BRAM write enable, registered
//   o_wr_addr  out  BRAM write address, registered [NB_ADDR]
//   o_wr_data  out  BRAM write data, registered [NB_DATA]
//   o_busy     out  high while arming or writing
//   o_done     out  high while the completed capture is held
// ---------------------------------------------------------------------------
module ram_wr_fsm #(
    parameter int NB_DATA = 16,
    parameter int NB_ADDR = 10
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
`ifdef RAM_WR_TRIGGER_EN
    input  logic               i_trigger,
`endif
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_wr_data,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARM   = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

    state_t             r_state;
    state_t             w_nextState;
    logic [NB_ADDR-1:0] r_wrCount;
    logic               w_accept;
    logic               w_lastAddr;

    // A sample is written only while in WRITE. Samples seen in IDLE, ARM or
    // DONE are dropped.
    assign w_accept   = (r_state == WRITE) && i_valid;
    assign w_lastAddr = (r_wrCount == LAST_ADDR);

    // State register
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. IDLE shares the default branch, so any encoding not
    // listed explicitly (ARM when the trigger is compiled out) acts as IDLE.
    // i_run is not looked at in ARM/WRITE, so a started capture always fills
    // the whole memory.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
`ifdef RAM_WR_TRIGGER_EN
            ARM: begin
                if (i_trigger) begin
                    w_nextState = WRITE;
                end
            end
`endif
            WRITE: begin
                if (w_accept && w_lastAddr) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (!i_run) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                if (i_run) begin
`ifdef RAM_WR_TRIGGER_EN
                    w_nextState = ARM;
`else
                    w_nextState = WRITE;
`endif
                end else begin
                    w_nextState = IDLE;
                end
            end
        endcase
    end

    // Status outputs are decoded from the registered state only.
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
`ifdef RAM_WR_TRIGGER_EN
            ARM:     o_busy = 1'b1;
`endif
            WRITE:   o_busy = 1'b1;
            DONE:    o_done = 1'b1;
            default: begin
                o_busy = 1'b0;
                o_done = 1'b0;
            end
        endcase
    end

    // Write datapath: an accepted sample produces exactly one o_wr_en pulse
    // on the following cycle. Address and data hold through valid gaps.
    // The counter wraps to 0 naturally on the last address. It is also
    // forced to 0 whenever the FSM heads to IDLE, so every run starts at
    // address 0. Reset drops any write accepted in the reset cycle.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_wrCount <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en <= w_accept;
            if (w_accept) begin
                o_wr_addr <= r_wrCount;
                o_wr_data <= i_data;
            end
            if (w_nextState == IDLE) begin
                r_wrCount <= '0;
            end else if (w_accept) begin
                r_wrCount <= r_wrCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_wr_fsm.sv
// ---------------------------------------------------------------------------
// tb_ram_wr_fsm
//
// Directed bench for ram_wr_fsm with an 8-deep capture (NB_ADDR = 3).
// Each step drives inputs, advances one clock edge and samples the outputs
// 1 time unit after that edge. Expected values are written out by hand or
// tracked with a small write counter kept by the bench.
// ---------------------------------------------------------------------------
module tb_ram_wr_fsm;

    localparam int NB_DATA = 16;
    localparam int NB_ADDR = 3;

    logic               clock;
    logic               i_reset;
    logic               i_run;
    logic               i_valid;
    logic [NB_DATA-1:0] i_data;
`ifdef RAM_WR_TRIGGER_EN
    logic               i_trigger;
`endif
    logic               o_wr_en;
    logic [NB_ADDR-1:0] o_wr_addr;
    logic [NB_DATA-1:0] o_wr_data;
    logic               o_busy;
    logic               o_done;

    int checks = 0;
    int errors = 0;

    ram_wr_fsm #(
        .NB_DATA(NB_DATA),
        .NB_ADDR(NB_ADDR)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_run    (i_run),
        .i_valid  (i_valid),
        .i_data   (i_data),
`ifdef RAM_WR_TRIGGER_EN
        .i_trigger(i_trigger),
`endif
        .o_wr_en  (o_wr_en),
        .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    // 10-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive inputs for the next edge
    task automatic applyStimulus(input logic run, input logic valid,
                                 input logic [NB_DATA-1:0] data);
        i_run   = run;
        i_valid = valid;
        i_data  = data;
    endtask

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Compare every output against its expected value
    task automatic checkOutput(input string tag, input logic expWrEn,
                               input logic [NB_ADDR-1:0] expAddr,
                               input logic [NB_DATA-1:0] expData,
                               input logic expBusy, input logic expDone);
        checks++;
        assert (o_wr_en === expWrEn) else begin
            errors++;
            $error("[TB] FAIL %s wr_en got %b want %b", tag, o_wr_en, expWrEn);
        end
        checks++;
        assert (o_wr_addr === expAddr) else begin
            errors++;
            $error("[TB] FAIL %s wr_addr got %0d want %0d", tag, o_wr_addr, expAddr);
        end
        checks++;
        assert (o_wr_data === expData) else begin
            errors++;
            $error("[TB] FAIL %s wr_data got %h want %h", tag, o_wr_data, expData);
        end
        checks++;
        assert (o_busy === expBusy) else begin
            errors++;
            $error("[TB] FAIL %s busy got %b want %b", tag, o_busy, expBusy);
        end
        checks++;
        assert (o_done === expDone) else begin
            errors++;
            $error("[TB] FAIL %s done got %b want %b", tag, o_done, expDone);
        end
    endtask

    initial begin
        int writes;
        logic [NB_ADDR-1:0] lastAddr;
        logic [NB_DATA-1:0] lastData;

        // Reset
        i_reset = 1'b1;
`ifdef RAM_WR_TRIGGER_EN
        i_trigger = 1'b0;
`endif
        applyStimulus(1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        i_reset = 1'b0;
        checkOutput("reset", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

`ifndef RAM_WR_TRIGGER_EN
        // Continuous valid, run held: writes 0..7 with data 0x10..0x17
        applyStimulus(1'b1, 1'b1, 16'h00EE);
        tick();
        checkOutput("enter_write", 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0010 + 16'(i));
            tick();
            checkOutput($sformatf("cont_w%0d", i), 1'b1, 3'(i), 16'h0010 + 16'(i),
                        (i < 7), (i == 7));
        end
        applyStimulus(1'b1, 1'b1, 16'h0099);
        tick();
        checkOutput("cont_done", 1'b0, 3'd7, 16'h0017, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("cont_idle", 1'b0, 3'd7, 16'h0017, 1'b0, 1'b0);

        // Valid pattern 1,0,0,1: addresses must step by one per accepted sample
        applyStimulus(1'b1, 1'b0, 16'h0000);
        tick();
        checkOutput("gap_enter", 1'b0, 3'd7, 16'h0017, 1'b1, 1'b0);
        writes   = 0;
        lastAddr = 3'd7;
        lastData = 16'h0017;
        for (int k = 0; k < 40 && writes < 8; k++) begin
            logic v;
            v = ((k % 4) == 0) || ((k % 4) == 3);
            applyStimulus(1'b1, v, 16'h0040 + 16'(k));
            tick();
            if (v) begin
                lastAddr = 3'(writes);
                lastData = 16'h0040 + 16'(k);
                writes++;
            end
            checkOutput($sformatf("gap_k%0d", k), v, lastAddr, lastData,
                        (writes < 8), (writes == 8));
        end
        checks++;
        assert (writes == 8) else begin
            errors++;
            $error("[TB] FAIL gap_count got %0d want 8", writes);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("gap_idle", 1'b0, 3'd7, lastData, 1'b0, 1'b0);

        // Reset after 4 writes suppresses the pending write
        applyStimulus(1'b1, 1'b1, 16'h0000);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0050 + 16'(i));
            tick();
            checkOutput($sformatf("pre_rst_w%0d", i), 1'b1, 3'(i), 16'h0050 + 16'(i),
                        1'b1, 1'b0);
        end
        i_reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h0099);
        tick();
        i_reset = 1'b0;
        checkOutput("mid_reset", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // New run from address 0, run dropped mid-WRITE: all 8 still written
        applyStimulus(1'b1, 1'b1, 16'h0060);
        tick();
        checkOutput("rerun_enter", 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i == 0), 1'b1, 16'h0060 + 16'(i));
            tick();
            checkOutput($sformatf("drop_w%0d", i), 1'b1, 3'(i), 16'h0060 + 16'(i),
                        (i < 7), (i == 7));
        end
        applyStimulus(1'b0, 1'b1, 16'h0099);
        tick();
        checkOutput("drop_idle", 1'b0, 3'd7, 16'h0067, 1'b0, 1'b0);

        // DONE held for 5 cycles by i_run, then release and restart at 0
        applyStimulus(1'b1, 1'b1, 16'h0000);
        tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0070 + 16'(i));
            tick();
        end
        checkOutput("hold_d1", 1'b1, 3'd7, 16'h0077, 1'b0, 1'b1);
        for (int i = 2; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000);
            tick();
            checkOutput($sformatf("hold_d%0d", i), 1'b0, 3'd7, 16'h0077, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("hold_idle", 1'b0, 3'd7, 16'h0077, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0080);
        tick();
        checkOutput("restart_enter", 1'b0, 3'd7, 16'h0077, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0081);
        tick();
        checkOutput("restart_w0", 1'b1, 3'd0, 16'h0081, 1'b1, 1'b0);
`else
        // Trigger build: no writes while armed, trigger-cycle sample dropped
        applyStimulus(1'b1, 1'b1, 16'h00A0);
        tick();
        checkOutput("arm_enter", 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h00A1 + 16'(i));
            tick();
            checkOutput($sformatf("armed_%0d", i), 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        end
        i_trigger = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h00A5);
        tick();
        i_trigger = 1'b0;
        checkOutput("trig_cycle", 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h00B0);
        tick();
        checkOutput("trig_w0", 1'b1, 3'd0, 16'h00B0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h00B1);
        tick();
        checkOutput("trig_w1", 1'b1, 3'd1, 16'h00B1, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
